// File: rtl/peripheral_gpio.sv
// peripheral_gpio
//   Memory-mapped 8-bit GPIO block. Eight output pins are driven from DATA_OUT,
//   with separate SET and CLR aliases. Eight asynchronous input pins go through
//   a two-flop synchronizer and a tick-based three-sample debouncer. Qualified
//   edges are captured in sticky RISE/FALL flags (write-1-to-clear) that feed a
//   level irq.
//
//   Register map (addr):
//     0 DATA_OUT  RW  [7:0]     4 RISE      RW1C [7:0]
//     1 SET       WO  (reads 0) 5 FALL      RW1C [7:0]
//     2 CLR       WO  (reads 0) 6 DEBOUNCE  RW   [15:0]
//     3 DATA_IN   RO  [7:0]     7 RAW       RO   [7:0]
//
//   Ports:
//     clk       system clock
//     rst       synchronous active-high reset
//     d_in      bus write data
//     cs        chip select
//     addr      word address
//     rd, wr    read / write strobes
//     d_out     registered read data (holds between reads)
//     gpio_in   asynchronous input pins
//     gpio_out  output pin levels
//     irq       OR of all RISE and FALL flags
module peripheral_gpio #(
    parameter int          clk_freq = 25000000,
    parameter logic [15:0] DB_RESET = 16'd24999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [2:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        irq
);

    localparam logic [2:0] A_DATA_OUT = 3'd0;
    localparam logic [2:0] A_SET      = 3'd1;
    localparam logic [2:0] A_CLR      = 3'd2;
    localparam logic [2:0] A_DATA_IN  = 3'd3;
    localparam logic [2:0] A_RISE     = 3'd4;
    localparam logic [2:0] A_FALL     = 3'd5;
    localparam logic [2:0] A_DEBOUNCE = 3'd6;
    localparam logic [2:0] A_RAW      = 3'd7;

    logic [31:0] dout_q, dout_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [7:0]  data_in_q, data_in_d;
    logic [7:0]  rise_q, rise_d;
    logic [7:0]  fall_q, fall_d;
    logic [15:0] debounce_q, debounce_d;
    logic [15:0] pre_q, pre_d;
    logic [7:0]  sync1_q, sync2_q;
    logic [7:0]  h0_q, h0_d;
    logic [7:0]  h1_q, h1_d;

    logic        wr_en, rd_en, tick;
    logic [7:0]  qual, rise_clr, fall_clr;
    logic        unused_bits;

    // clk_freq is informational; upper write-data bits have no home
    assign unused_bits = ^{d_in[31:16], clk_freq[0]};

    assign wr_en = cs & wr;
    assign rd_en = cs & rd;
    assign tick  = (pre_q == debounce_q);

    always_comb begin
        data_out_d = data_out_q;
        debounce_d = debounce_q;
        rise_clr   = 8'h00;
        fall_clr   = 8'h00;
        dout_d     = dout_q;
        pre_d      = tick ? 16'd0 : pre_q + 16'd1;

        if (wr_en) begin
            case (addr)
                A_DATA_OUT: data_out_d = d_in[7:0];
                A_SET:      data_out_d = data_out_q | d_in[7:0];
                A_CLR:      data_out_d = data_out_q & ~d_in[7:0];
                A_RISE:     rise_clr   = d_in[7:0];
                A_FALL:     fall_clr   = d_in[7:0];
                A_DEBOUNCE: begin
                    debounce_d = d_in[15:0];
                    // restart the prescaler so a smaller terminal count never
                    // has to wait for a wrap through 65535
                    pre_d      = 16'd0;
                end
                default: ;
            endcase
        end

        if (rd_en) begin
            case (addr)
                A_DATA_OUT: dout_d = {24'd0, data_out_q};
                A_DATA_IN:  dout_d = {24'd0, data_in_q};
                A_RISE:     dout_d = {24'd0, rise_q};
                A_FALL:     dout_d = {24'd0, fall_q};
                A_DEBOUNCE: dout_d = {16'd0, debounce_q};
                A_RAW:      dout_d = {24'd0, sync2_q};
                default:    dout_d = 32'd0;
            endcase
        end
    end

    // A bit qualifies when three consecutive tick samples agree and differ
    // from the current debounced level.
    always_comb begin
        h0_d = h0_q;
        h1_d = h1_q;
        qual = 8'h00;
        if (tick) begin
            h0_d = sync2_q;
            h1_d = h0_q;
            qual = ~(sync2_q ^ h0_q) & ~(h0_q ^ h1_q) & (sync2_q ^ data_in_q);
        end
    end

    // Set beats a same-edge clear so a W1C never hides a fresh edge.
    assign data_in_d = (data_in_q & ~qual) | (sync2_q & qual);
    assign rise_d    = (rise_q & ~rise_clr) | (qual & sync2_q);
    assign fall_d    = (fall_q & ~fall_clr) | (qual & ~sync2_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q     <= 32'd0;
            data_out_q <= 8'h00;
            data_in_q  <= 8'h00;
            rise_q     <= 8'h00;
            fall_q     <= 8'h00;
            debounce_q <= DB_RESET;
            pre_q      <= 16'd0;
            sync1_q    <= 8'h00;
            sync2_q    <= 8'h00;
            h0_q       <= 8'h00;
            h1_q       <= 8'h00;
        end else begin
            dout_q     <= dout_d;
            data_out_q <= data_out_d;
            data_in_q  <= data_in_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            debounce_q <= debounce_d;
            pre_q      <= pre_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            h0_q       <= h0_d;
            h1_q       <= h1_d;
        end
    end

    assign d_out    = dout_q;
    assign gpio_out = data_out_q;
    assign irq      = |(rise_q | fall_q);

endmodule

// File: tb/tb_peripheral_gpio.sv
module tb_peripheral_gpio;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_in;
    logic        cs;
    logic [2:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_out;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    peripheral_gpio #(
        .clk_freq (25000000),
        .DB_RESET (16'd24999)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .cs       (cs),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .d_out    (d_out),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_wr;
        logic [2:0]  a;
        logic [31:0] data;
        logic [31:0] exp;   // gpio_out after a write, d_out after a read
        string       name;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; d_in = 32'd0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        d = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
        logic [31:0] v;
        bus_rd(a, v);
        check(name, v, exp);
    endtask

    initial begin
        logic [31:0] v;
        int          cyc_r;
        int          elapsed;

        vecs[0]  = '{1'b0, 3'd0, 32'd0,     32'd0,     "rst_data_out"};
        vecs[1]  = '{1'b0, 3'd1, 32'd0,     32'd0,     "rst_set"};
        vecs[2]  = '{1'b0, 3'd2, 32'd0,     32'd0,     "rst_clr"};
        vecs[3]  = '{1'b0, 3'd3, 32'd0,     32'd0,     "rst_data_in"};
        vecs[4]  = '{1'b0, 3'd4, 32'd0,     32'd0,     "rst_rise"};
        vecs[5]  = '{1'b0, 3'd5, 32'd0,     32'd0,     "rst_fall"};
        vecs[6]  = '{1'b0, 3'd6, 32'd0,     32'd24999, "rst_debounce"};
        vecs[7]  = '{1'b0, 3'd7, 32'd0,     32'd0,     "rst_raw"};
        vecs[8]  = '{1'b1, 3'd0, 32'hA5,    32'hA5,    "wr_data_out"};
        vecs[9]  = '{1'b1, 3'd1, 32'h0F,    32'hAF,    "wr_set"};
        vecs[10] = '{1'b1, 3'd2, 32'h81,    32'h2E,    "wr_clr"};
        vecs[11] = '{1'b0, 3'd0, 32'd0,     32'h2E,    "rd_data_out"};
        vecs[12] = '{1'b0, 3'd1, 32'd0,     32'd0,     "rd_set_zero"};
        vecs[13] = '{1'b0, 3'd2, 32'd0,     32'd0,     "rd_clr_zero"};
        vecs[14] = '{1'b1, 3'd3, 32'hFF,    32'h2E,    "wr_ro_data_in"};
        vecs[15] = '{1'b0, 3'd3, 32'd0,     32'd0,     "rd_data_in_ro"};
        vecs[16] = '{1'b1, 3'd6, 32'h1_0000, 32'h2E,   "wr_debounce0"};
        vecs[17] = '{1'b0, 3'd6, 32'd0,     32'd0,     "rd_debounce0"};

        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 3'd0;
        d_in = 32'd0; gpio_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_gpio_out", {24'd0, gpio_out}, 32'h00);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_d_out", d_out, 32'd0);

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_wr) begin
                bus_wr(vecs[i].a, vecs[i].data);
                check(vecs[i].name, {24'd0, gpio_out}, vecs[i].exp);
            end else begin
                bus_rd(vecs[i].a, v);
                check(vecs[i].name, v, vecs[i].exp);
            end
        end

        // d_out holds between reads
        bus_rd(3'd0, v);
        repeat (3) @(negedge clk);
        check("d_out_hold", d_out, 32'h2E);

        // DEBOUNCE = 0: change latched by sync1 at edge N visible after N+4
        @(negedge clk);
        gpio_in = 8'h08;
        repeat (4) @(posedge clk);
        #1 check("irq_before_n4", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1 check("irq_at_n4", {31'd0, irq}, 32'd1);
        rd_chk(3'd3, 32'h08, "data_in_pin3");
        rd_chk(3'd4, 32'h08, "rise_pin3");
        rd_chk(3'd7, 32'h08, "raw_pin3");
        rd_chk(3'd5, 32'h00, "fall_none");
        bus_wr(3'd4, 32'h08);
        check("irq_after_w1c", {31'd0, irq}, 32'd0);
        rd_chk(3'd4, 32'h00, "rise_cleared");

        // DEBOUNCE = 9: a 15-cycle pulse spans at most two ticks
        bus_wr(3'd6, 32'd9);
        rd_chk(3'd6, 32'd9, "rd_debounce9");
        @(negedge clk);
        gpio_in = 8'h09;
        repeat (15) @(negedge clk);
        gpio_in = 8'h08;
        repeat (40) @(negedge clk);
        rd_chk(3'd3, 32'h08, "glitch_data_in");
        rd_chk(3'd4, 32'h00, "glitch_rise");
        check("glitch_irq", {31'd0, irq}, 32'd0);

        // DEBOUNCE = 0: W1C of FALL[2] on the same edge as a fall on pin 2
        bus_wr(3'd6, 32'd0);
        @(negedge clk);
        gpio_in = 8'h0C;
        repeat (8) @(negedge clk);
        rd_chk(3'd3, 32'h0C, "pin2_high");
        bus_wr(3'd4, 32'hFF);
        rd_chk(3'd4, 32'h00, "rise_all_cleared");
        gpio_in = 8'h08;                 // captured by sync1 at edge N
        repeat (4) @(posedge clk);       // now at edge N+3
        bus_wr(3'd5, 32'h04);            // write sampled at edge N+4
        rd_chk(3'd5, 32'h04, "fall_set_wins");
        check("irq_fall", {31'd0, irq}, 32'd1);
        rd_chk(3'd3, 32'h08, "data_in_pin2_low");
        bus_wr(3'd5, 32'h04);
        rd_chk(3'd5, 32'h00, "fall_cleared");
        rd_chk(3'd7, 32'h08, "raw_before_reset");

        // reset mid-qualification on pin 5
        @(negedge clk);
        gpio_in = 8'h20;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 cyc_r = cyc;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_gpio_out", {24'd0, gpio_out}, 32'h00);
        check("rst2_irq", {31'd0, irq}, 32'd0);
        check("rst2_d_out", d_out, 32'd0);
        rd_chk(3'd0, 32'h00, "rst2_data_out");
        rd_chk(3'd3, 32'h00, "rst2_data_in");
        rd_chk(3'd4, 32'h00, "rst2_rise");
        rd_chk(3'd5, 32'h00, "rst2_fall");
        rd_chk(3'd6, 32'd24999, "rst2_debounce");

        while (irq !== 1'b1 && (cyc - cyc_r) < 80000) @(negedge clk);
        elapsed = cyc - cyc_r;
        check("requal_irq", {31'd0, irq}, 32'd1);
        check("requal_not_early", {31'd0, elapsed >= 75000}, 32'd1);
        check("requal_not_late", {31'd0, elapsed <= 75003}, 32'd1);
        rd_chk(3'd4, 32'h20, "requal_rise");
        rd_chk(3'd3, 32'h20, "requal_data_in");
        rd_chk(3'd5, 32'h00, "requal_fall");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
